// File: rtl/uart_pkg.sv
// uart_pkg -- shared definitions for the UART receiver slice.
//   DATA_BITS_DEF  : default number of data bits per frame
//   OVERSAMPLE_DEF : default number of rx_enb ticks per bit period
//   MID_SAMPLE     : tick index inside the start bit where it is re-checked
//   rx_state_t     : receiver FSM states (PARITY exists only when
//                    UART_RX_PARITY_EN is defined)
package uart_pkg;

  localparam int DATA_BITS_DEF  = 8;
  localparam int OVERSAMPLE_DEF = 16;
  localparam int MID_SAMPLE     = OVERSAMPLE_DEF / 2 - 1;

  // Mid-bit tick index for an arbitrary oversample ratio.
  function automatic int mid_sample(input int oversample);
    return oversample / 2 - 1;
  endfunction

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3
`ifdef UART_RX_PARITY_EN
    , PARITY = 3'd4
`endif
  } rx_state_t;

endpackage

// File: rtl/uart_receiver_if.sv
// uart_receiver_if -- consumer-side bundle of the UART receiver.
//   data       : last received word
//   ready      : new word available in data
//   ready_clr  : consumer acknowledge, clears ready
//   frame_err  : stop bit of the last frame sampled low
//   overrun    : a frame completed while ready was still high
//   parity_err : even-parity check of the last frame (UART_RX_PARITY_EN only)
// Modports: master = receiver, slave = consumer.
interface uart_receiver_if
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF
);

  logic [DATA_BITS-1:0] data;
  logic                 ready;
  logic                 ready_clr;
  logic                 frame_err;
  logic                 overrun;
`ifdef UART_RX_PARITY_EN
  logic                 parity_err;

  modport master (output data, ready, frame_err, overrun, parity_err, input ready_clr);
  modport slave  (input data, ready, frame_err, overrun, parity_err, output ready_clr);
`else
  modport master (output data, ready, frame_err, overrun, input ready_clr);
  modport slave  (input data, ready, frame_err, overrun, output ready_clr);
`endif

endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync -- two-flop synchronizer for the asynchronous serial line.
//   clk   : system clock
//   rst_n : asynchronous active-low reset (flops reset to idle-high 1)
//   rx    : raw serial input
//   rx_s  : synchronized serial line
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic rx_s
);

  logic [1:0] sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_reg <= 2'b11;
    else        sync_reg <= {sync_reg[0], rx};
  end

  assign rx_s = sync_reg[1];

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver -- oversampling UART receiver (start, DATA_BITS data LSB
// first, optional even parity, one stop bit).
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   rx_enb : one-clk oversample tick, OVERSAMPLE per bit period
//   rx     : asynchronous serial line, idle high
//   bus    : uart_receiver_if.master (data/ready/ready_clr/frame_err/overrun
//            and parity_err)
// Optional feature: define UART_RX_PARITY_EN to add the PARITY state and the
// parity_err output.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rx_enb,
  input  logic            rx,
  uart_receiver_if.master bus
);

  localparam int CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(mid_sample(OVERSAMPLE));
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  logic rx_s;

  uart_rx_sync u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .rx   (rx),
    .rx_s (rx_s)
  );

  rx_state_t            state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg,   cnt_next;
  logic [BIT_W-1:0]     bit_reg,   bit_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic [DATA_BITS-1:0] data_reg,  data_next;
  logic                 ready_reg, ready_next;
  logic                 ferr_reg,  ferr_next;
  logic                 ovr_reg,   ovr_next;
  logic                 done;
`ifdef UART_RX_PARITY_EN
  logic                 par_reg,   par_next;
  logic                 perr_reg,  perr_next;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      data_reg  <= '0;
      ready_reg <= 1'b0;
      ferr_reg  <= 1'b0;
      ovr_reg   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_reg   <= 1'b0;
      perr_reg  <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      data_reg  <= data_next;
      ready_reg <= ready_next;
      ferr_reg  <= ferr_next;
      ovr_reg   <= ovr_next;
`ifdef UART_RX_PARITY_EN
      par_reg   <= par_next;
      perr_reg  <= perr_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    data_next  = data_reg;
    ferr_next  = ferr_reg;
    done       = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_next   = par_reg;
    perr_next  = perr_reg;
`endif
    // Frame sequencing only moves on oversample ticks.
    if (rx_enb) begin
      case (state_reg)
        IDLE: begin
          if (!rx_s) begin
            state_next = START;
            cnt_next   = '0;
          end
        end
        START: begin
          // Re-check the line at the start-bit midpoint; a high line here is
          // a glitch, not a frame.
          if (cnt_reg == CNT_MID) begin
            cnt_next   = '0;
            bit_next   = '0;
            state_next = rx_s ? IDLE : DATA;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt_reg == CNT_LAST) begin
            cnt_next            = '0;
            shift_next[bit_reg] = rx_s;
            if (bit_reg == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_next = PARITY;
`else
              state_next = STOP;
`endif
            end else begin
              bit_next = bit_reg + BIT_W'(1);
            end
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt_reg == CNT_LAST) begin
            cnt_next   = '0;
            par_next   = rx_s;
            state_next = STOP;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
`endif
        STOP: begin
          if (cnt_reg == CNT_LAST) begin
            cnt_next   = '0;
            done       = 1'b1;
            data_next  = shift_reg;
            ferr_next  = ~rx_s;
`ifdef UART_RX_PARITY_EN
            // Even parity: data bits plus parity bit must XOR to zero.
            perr_next  = (^shift_reg) ^ par_reg;
`endif
            state_next = IDLE;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Handshake runs every clock; a completion wins over a coincident clear.
  always_comb begin
    ready_next = ready_reg;
    ovr_next   = ovr_reg;
    if (done)               ready_next = 1'b1;
    else if (bus.ready_clr) ready_next = 1'b0;
    if (bus.ready_clr)            ovr_next = 1'b0;
    else if (done && ready_reg)   ovr_next = 1'b1;
  end

  assign bus.data      = data_reg;
  assign bus.ready     = ready_reg;
  assign bus.frame_err = ferr_reg;
  assign bus.overrun   = ovr_reg;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = perr_reg;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver -- directed plus randomized frames against a
// frame-level expectation model. The baud tick is compressed (one rx_enb
// every TICK_PERIOD clocks) to keep the run short; the receiver only sees
// ticks, so the bit timing relative to ticks is unchanged.
module tb_uart_receiver;

  localparam int DATA_BITS   = 8;
  localparam int OVERSAMPLE  = 16;
  localparam int TICK_PERIOD = 4;
`ifdef UART_RX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int FRAME_BITS  = 1 + DATA_BITS + PAR_BITS + 1;
  localparam int FRAME_TICKS = OVERSAMPLE * FRAME_BITS;
  // Start seen on tick 1, midpoint re-check 8 ticks later, then one sample
  // every OVERSAMPLE ticks; the stop bit is frame bit FRAME_BITS-1.
  localparam int DONE_K = 1 + OVERSAMPLE / 2 + OVERSAMPLE * (FRAME_BITS - 1);

  logic clk = 1'b0;
  logic rst_n;
  logic rx_enb = 1'b0;
  logic rx;
  int   div = 0;

  uart_receiver_if #(.DATA_BITS(DATA_BITS)) bus_if ();

  uart_receiver #(.DATA_BITS(DATA_BITS), .OVERSAMPLE(OVERSAMPLE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rx_enb(rx_enb),
    .rx    (rx),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  // Tick generator updates on the falling edge so rx_enb is stable at posedge.
  always @(negedge clk) begin
    div    <= (div == TICK_PERIOD - 1) ? 0 : div + 1;
    rx_enb <= (div == 0);
  end

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_data;
  logic       exp_ready, exp_ferr, exp_ovr, exp_perr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":data"},      32'(bus_if.data),      32'(exp_data));
    chk({tag, ":ready"},     32'(bus_if.ready),     32'(exp_ready));
    chk({tag, ":frame_err"}, 32'(bus_if.frame_err), 32'(exp_ferr));
    chk({tag, ":overrun"},   32'(bus_if.overrun),   32'(exp_ovr));
`ifdef UART_RX_PARITY_EN
    chk({tag, ":parity_err"}, 32'(bus_if.parity_err), 32'(exp_perr));
`endif
  endtask

  task automatic wait_tick();
    int guard = 0;
    do begin
      @(posedge clk);
      guard++;
    end while (!rx_enb && guard < 100);
    if (guard >= 100) chk("tick_timeout", 32'(guard), 32'd0);
  endtask

  // Drives one frame; stop_at != 0 abandons the frame at that tick.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_bit,
                            input logic clr_at_done, input int stop_at, input string tag);
    logic frame [FRAME_BITS];
    frame[0] = 1'b0;
    for (int i = 0; i < DATA_BITS; i++) frame[1 + i] = b[i];
    if (PAR_BITS == 1) frame[1 + DATA_BITS] = par_bit;
    frame[FRAME_BITS - 1] = stop_bit;
    wait_tick();
    #1 rx = frame[0];
    for (int k = 1; k <= FRAME_TICKS; k++) begin
      wait_tick();
      #1;
      if (stop_at != 0 && k == stop_at) return;
      if (k == DONE_K) begin
        bus_if.ready_clr = 1'b0;
        if (clr_at_done) exp_ovr = 1'b0;
        else if (exp_ready) exp_ovr = 1'b1;
        exp_ready = 1'b1;
        exp_data  = b;
        exp_ferr  = ~stop_bit;
        exp_perr  = (^b) ^ par_bit;
        check_all({tag, "@stop"});
      end
      if (k == DONE_K - 1) begin
        chk({tag, ":ready_before_stop"}, 32'(bus_if.ready), 32'(exp_ready));
        if (clr_at_done) begin
          // Raise ready_clr for exactly the clock that carries the stop tick.
          repeat (TICK_PERIOD - 1) @(posedge clk);
          #1 bus_if.ready_clr = 1'b1;
        end
      end
      if (k % OVERSAMPLE == 0 && k < FRAME_TICKS) rx = frame[k / OVERSAMPLE];
    end
    rx = 1'b1;
    repeat (12) wait_tick();
  endtask

  task automatic clear_ready(input string tag);
    @(posedge clk);
    #1 bus_if.ready_clr = 1'b1;
    @(posedge clk);
    #1 bus_if.ready_clr = 1'b0;
    exp_ready = 1'b0;
    exp_ovr   = 1'b0;
    chk({tag, ":ready_cleared"},   32'(bus_if.ready),   32'd0);
    chk({tag, ":overrun_cleared"}, 32'(bus_if.overrun), 32'd0);
  endtask

  initial begin
    logic [7:0] rb;
    logic       rstop, rpar, rclr;

    rst_n = 1'b0;
    rx = 1'b1;
    bus_if.ready_clr = 1'b0;
    exp_data = 8'h00; exp_ready = 1'b0; exp_ferr = 1'b0; exp_ovr = 1'b0; exp_perr = 1'b0;
    repeat (5) @(posedge clk);
    #1 check_all("reset");
    rst_n = 1'b1;
    repeat (4) wait_tick();

    // Normal frame
    send_frame(8'h55, 1'b1, ^8'h55, 1'b0, 0, "normal_55");
    clear_ready("normal_55");

    // Glitch: start bit shorter than half a bit period is rejected
    wait_tick();
    #1 rx = 1'b0;
    repeat (3) wait_tick();
    #1 rx = 1'b1;
    repeat (20) wait_tick();
    #1 check_all("glitch");

    // Framing error then a good frame
    send_frame(8'hA5, 1'b0, ^8'hA5, 1'b0, 0, "ferr_A5");
    send_frame(8'h3C, 1'b1, ^8'h3C, 1'b0, 0, "good_3C");
    clear_ready("good_3C");

    // Overrun and set-wins handshake
    send_frame(8'h11, 1'b1, ^8'h11, 1'b0, 0, "ovr_11");
    send_frame(8'h22, 1'b1, ^8'h22, 1'b0, 0, "ovr_22");
    send_frame(8'h33, 1'b1, ^8'h33, 1'b1, 0, "clr_at_done_33");
    clear_ready("clr_at_done_33");

    // Parity checks (parity bit ignored when the feature is absent)
    send_frame(8'h07, 1'b1, 1'b0, 1'b0, 0, "par0_07");
    send_frame(8'h07, 1'b1, 1'b1, 1'b0, 0, "par1_07");

    // Reset mid-frame, after data bit 3 has been sampled; ready is high here
    send_frame(8'hF0, 1'b1, ^8'hF0, 1'b0, 1 + OVERSAMPLE / 2 + OVERSAMPLE * 4 + 3, "rst_F0");
    #2 rst_n = 1'b0;
    rx = 1'b1;
    exp_data = 8'h00; exp_ready = 1'b0; exp_ferr = 1'b0; exp_ovr = 1'b0; exp_perr = 1'b0;
    #1 check_all("async_reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (FRAME_TICKS + 20) wait_tick();
    #1 check_all("after_reset_idle");
    send_frame(8'hC3, 1'b1, ^8'hC3, 1'b0, 0, "post_reset_C3");
    clear_ready("post_reset_C3");

    // Randomized frames
    for (int n = 0; n < 12; n++) begin
      rb    = 8'($urandom);
      rstop = ($urandom_range(0, 3) != 0);
      rpar  = (^rb) ^ ($urandom_range(0, 3) == 0);
      rclr  = ($urandom_range(0, 3) == 0);
      send_frame(rb, rstop, rpar, rclr, 0, $sformatf("rand%0d_%02h", n, rb));
      if ($urandom_range(0, 1) == 1) clear_ready($sformatf("rand%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
